// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the five-stage MIPS core: payload, register-write
// controls and Tnew, with stall/flush, hazard-query outputs and a saturating stall counter.
module pipe_stage_reg #(
    parameter int unsigned PAYLOAD_W         = 136,
    parameter int unsigned REG_W             = 5,
    parameter int unsigned TNEW_W            = 2,
    parameter int unsigned TNEW_DEC_ON_STALL = 1,
    parameter int unsigned CNT_W             = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 valid_in,
    input  logic [PAYLOAD_W-1:0] payload_in,
    input  logic                 reg_write_in,
    input  logic [REG_W-1:0]     write_reg_in,
    input  logic [TNEW_W-1:0]    tnew_in,
    input  logic [REG_W-1:0]     src_a,
    input  logic [REG_W-1:0]     src_b,
    output logic                 valid_out,
    output logic [PAYLOAD_W-1:0] payload_out,
    output logic                 reg_write_out,
    output logic [REG_W-1:0]     write_reg_out,
    output logic [TNEW_W-1:0]    tnew_out,
    output logic                 hit_a,
    output logic                 hit_b,
    output logic                 ready_a,
    output logic                 ready_b,
    output logic [CNT_W-1:0]     stall_cnt
);

    logic                 r_valid;
    logic [PAYLOAD_W-1:0] r_payload;
    logic                 r_reg_write;
    logic [REG_W-1:0]     r_write_reg;
    logic [TNEW_W-1:0]    r_tnew;
    logic [CNT_W-1:0]     r_stall_cnt;

    logic [TNEW_W-1:0]    w_tnew_in_dec;
    logic [TNEW_W-1:0]    w_tnew_held;
    logic [CNT_W-1:0]     w_cnt_next;
    logic                 w_reg_write_eff;
    logic                 w_tnew_zero;

    // Tnew counts down toward zero and never wraps, both on entry and while held
    assign w_tnew_in_dec = (tnew_in == '0) ? '0 : tnew_in - TNEW_W'(1);
    assign w_tnew_held   = (TNEW_DEC_ON_STALL == 0) ? r_tnew :
                           ((r_tnew == '0) ? '0 : r_tnew - TNEW_W'(1));
    assign w_cnt_next    = (r_stall_cnt == '1) ? r_stall_cnt : r_stall_cnt + CNT_W'(1);

    // Priority: reset > flush > stall > advance
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_payload   <= '0;
            r_reg_write <= 1'b0;
            r_write_reg <= '0;
            r_tnew      <= '0;
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_valid     <= 1'b0;
            r_payload   <= '0;
            r_reg_write <= 1'b0;
            r_write_reg <= '0;
            r_tnew      <= '0;
        end else if (stall) begin
            r_tnew      <= w_tnew_held;
            r_stall_cnt <= w_cnt_next;
        end else begin
            r_valid     <= valid_in;
            r_payload   <= payload_in;
            r_reg_write <= reg_write_in;
            r_write_reg <= write_reg_in;
            r_tnew      <= w_tnew_in_dec;
        end
    end

    // Hazard outputs depend only on held state and the query registers; $0 never matches
    assign w_reg_write_eff = r_valid & r_reg_write & (r_write_reg != '0);
    assign w_tnew_zero     = (r_tnew == '0);

    assign valid_out     = r_valid;
    assign payload_out   = r_payload;
    assign reg_write_out = w_reg_write_eff;
    assign write_reg_out = r_write_reg;
    assign tnew_out      = r_tnew;
    assign stall_cnt     = r_stall_cnt;

    assign hit_a   = w_reg_write_eff & (r_write_reg == src_a);
    assign hit_b   = w_reg_write_eff & (r_write_reg == src_b);
    assign ready_a = hit_a & w_tnew_zero;
    assign ready_b = hit_b & w_tnew_zero;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default instance, a frozen-Tnew instance and a
// 4-bit stall counter instance, all driven with the same stimulus.
module tb_pipe_stage_reg;

    localparam int unsigned PW = 136;

    typedef struct {
        logic          rst, stl, fls, vin;
        logic [PW-1:0] pin;
        logic          rwin;
        logic [4:0]    wrin;
        logic [1:0]    tin;
        logic [4:0]    sa, sb;
        logic          e_valid;
        logic [PW-1:0] e_pay;
        logic          e_rw;
        logic [4:0]    e_wr;
        logic [1:0]    e_tnew, e_tfrz;
        logic          e_ha, e_hb, e_ra, e_rb;
        logic [15:0]   e_cnt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, stall, flush, valid_in, reg_write_in;
    logic [PW-1:0] payload_in;
    logic [4:0]    write_reg_in, src_a, src_b;
    logic [1:0]    tnew_in;

    logic          m_valid, m_rw, m_ha, m_hb, m_ra, m_rb;
    logic [PW-1:0] m_pay;
    logic [4:0]    m_wr;
    logic [1:0]    m_tnew;
    logic [15:0]   m_cnt;

    logic          f_valid, f_rw, f_ha, f_hb, f_ra, f_rb;
    logic [PW-1:0] f_pay;
    logic [4:0]    f_wr;
    logic [1:0]    f_tnew;
    logic [15:0]   f_cnt;

    logic          s_valid, s_rw, s_ha, s_hb, s_ra, s_rb;
    logic [PW-1:0] s_pay;
    logic [4:0]    s_wr;
    logic [1:0]    s_tnew;
    logic [3:0]    s_cnt;

    pipe_stage_reg u_main (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
        .payload_in(payload_in), .reg_write_in(reg_write_in), .write_reg_in(write_reg_in),
        .tnew_in(tnew_in), .src_a(src_a), .src_b(src_b),
        .valid_out(m_valid), .payload_out(m_pay), .reg_write_out(m_rw), .write_reg_out(m_wr),
        .tnew_out(m_tnew), .hit_a(m_ha), .hit_b(m_hb), .ready_a(m_ra), .ready_b(m_rb),
        .stall_cnt(m_cnt)
    );

    pipe_stage_reg #(.TNEW_DEC_ON_STALL(0)) u_frz (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
        .payload_in(payload_in), .reg_write_in(reg_write_in), .write_reg_in(write_reg_in),
        .tnew_in(tnew_in), .src_a(src_a), .src_b(src_b),
        .valid_out(f_valid), .payload_out(f_pay), .reg_write_out(f_rw), .write_reg_out(f_wr),
        .tnew_out(f_tnew), .hit_a(f_ha), .hit_b(f_hb), .ready_a(f_ra), .ready_b(f_rb),
        .stall_cnt(f_cnt)
    );

    pipe_stage_reg #(.CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
        .payload_in(payload_in), .reg_write_in(reg_write_in), .write_reg_in(write_reg_in),
        .tnew_in(tnew_in), .src_a(src_a), .src_b(src_b),
        .valid_out(s_valid), .payload_out(s_pay), .reg_write_out(s_rw), .write_reg_out(s_wr),
        .tnew_out(s_tnew), .hit_a(s_ha), .hit_b(s_hb), .ready_a(s_ra), .ready_b(s_rb),
        .stall_cnt(s_cnt)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input int idx, input logic [PW-1:0] act,
                       input logic [PW-1:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic rst, stl, fls, vin, input logic [PW-1:0] pin, input logic rwin,
        input logic [4:0] wrin, input logic [1:0] tin, input logic [4:0] sa, sb,
        input logic e_valid, input logic [PW-1:0] e_pay, input logic e_rw,
        input logic [4:0] e_wr, input logic [1:0] e_tnew, e_tfrz,
        input logic e_ha, e_hb, e_ra, e_rb, input logic [15:0] e_cnt);
        vec_t v;
        v.rst = rst; v.stl = stl; v.fls = fls; v.vin = vin; v.pin = pin; v.rwin = rwin;
        v.wrin = wrin; v.tin = tin; v.sa = sa; v.sb = sb;
        v.e_valid = e_valid; v.e_pay = e_pay; v.e_rw = e_rw; v.e_wr = e_wr;
        v.e_tnew = e_tnew; v.e_tfrz = e_tfrz; v.e_ha = e_ha; v.e_hb = e_hb;
        v.e_ra = e_ra; v.e_rb = e_rb; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic drive(input logic rst, stl, fls, vin, input logic [PW-1:0] pin,
                         input logic rwin, input logic [4:0] wrin, input logic [1:0] tin,
                         input logic [4:0] sa, sb);
        reset = rst; stall = stl; flush = fls; valid_in = vin; payload_in = pin;
        reg_write_in = rwin; write_reg_in = wrin; tnew_in = tin; src_a = sa; src_b = sb;
    endtask

    initial begin
        vec_t          vecs[13];
        logic [PW-1:0] ones, a5, x5a, p123, p77, z;
        logic [15:0]   sat_exp;

        ones = '1; a5 = {17{8'hA5}}; x5a = {17{8'h5A}}; p123 = PW'(12'h123);
        p77 = PW'(8'h77); z = '0;

        //            rst s f vin pin  rw wr tin sa sb   | val pay  rw wr tn tf ha hb ra rb cnt
        vecs[0]  = mk(1, 0, 0, 1, ones, 1, 31, 3, 31, 31,  0, z,    0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 1, ones, 1, 31, 3, 31, 31,  0, z,    0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 1, a5,   1, 8,  2, 8,  9,   1, a5,   1, 8, 1, 1, 1, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 1, x5a,  1, 8,  0, 8,  8,   1, x5a,  1, 8, 0, 0, 1, 1, 1, 1, 0);
        vecs[4]  = mk(0, 0, 0, 1, p123, 1, 0,  0, 0,  0,   1, p123, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 1, a5,   1, 12, 3, 12, 0,   1, a5,   1, 12, 2, 2, 1, 0, 0, 0, 0);
        vecs[6]  = mk(0, 1, 0, 0, ones, 0, 31, 3, 12, 31,  1, a5,   1, 12, 1, 2, 1, 0, 0, 0, 1);
        vecs[7]  = mk(0, 1, 0, 0, ones, 0, 31, 3, 12, 31,  1, a5,   1, 12, 0, 2, 1, 0, 1, 0, 2);
        vecs[8]  = mk(0, 1, 0, 0, ones, 0, 31, 3, 12, 31,  1, a5,   1, 12, 0, 2, 1, 0, 1, 0, 3);
        vecs[9]  = mk(0, 1, 1, 1, ones, 1, 31, 3, 31, 12,  0, z,    0, 0, 0, 0, 0, 0, 0, 0, 3);
        vecs[10] = mk(0, 0, 0, 0, p77,  1, 5,  1, 5,  5,   0, p77,  0, 5, 0, 0, 0, 0, 0, 0, 3);
        vecs[11] = mk(0, 0, 0, 1, p77,  0, 5,  2, 5,  5,   1, p77,  0, 5, 1, 1, 0, 0, 0, 0, 3);
        vecs[12] = mk(0, 0, 1, 1, ones, 1, 9,  3, 9,  9,   0, z,    0, 0, 0, 0, 0, 0, 0, 0, 3);

        drive(1, 0, 0, 0, z, 0, 0, 0, 0, 0);
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rst, vecs[i].stl, vecs[i].fls, vecs[i].vin, vecs[i].pin,
                  vecs[i].rwin, vecs[i].wrin, vecs[i].tin, vecs[i].sa, vecs[i].sb);
            @(posedge clk);
            #1;
            n_vec++;
            chk("valid_out",     i, PW'(m_valid), PW'(vecs[i].e_valid));
            chk("payload_out",   i, m_pay,         vecs[i].e_pay);
            chk("reg_write_out", i, PW'(m_rw),    PW'(vecs[i].e_rw));
            chk("write_reg_out", i, PW'(m_wr),    PW'(vecs[i].e_wr));
            chk("tnew_out",      i, PW'(m_tnew),  PW'(vecs[i].e_tnew));
            chk("hit_a",         i, PW'(m_ha),    PW'(vecs[i].e_ha));
            chk("hit_b",         i, PW'(m_hb),    PW'(vecs[i].e_hb));
            chk("ready_a",       i, PW'(m_ra),    PW'(vecs[i].e_ra));
            chk("ready_b",       i, PW'(m_rb),    PW'(vecs[i].e_rb));
            chk("stall_cnt",     i, PW'(m_cnt),   PW'(vecs[i].e_cnt));
            chk("frz_tnew_out",  i, PW'(f_tnew),  PW'(vecs[i].e_tfrz));
            chk("sat_stall_cnt", i, PW'(s_cnt),   PW'(vecs[i].e_cnt));
            @(negedge clk);
        end

        // Long stall: 16-bit counter keeps counting, 4-bit counter pins at 15
        drive(0, 0, 0, 1, a5, 1, 7, 3, 7, 0);
        @(posedge clk); #1;
        n_vec++;
        chk("load_tnew", 100, PW'(m_tnew), PW'(2'd2));
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 0, 0, ones, 0, 31, 0, 7, 0);
            @(posedge clk); #1;
            n_vec++;
            sat_exp = (3 + i + 1 > 15) ? 16'd15 : 16'(3 + i + 1);
            chk("sat_stall_cnt", 200 + i, PW'(s_cnt), PW'(sat_exp));
            chk("stall_cnt",     200 + i, PW'(m_cnt), PW'(16'(3 + i + 1)));
            @(negedge clk);
        end
        n_vec++;
        chk("long_stall_payload", 300, m_pay, a5);
        chk("long_stall_tnew",    300, PW'(m_tnew), PW'(2'd0));
        chk("long_stall_frz",     300, PW'(f_tnew), PW'(2'd2));
        chk("long_stall_ready_a", 300, PW'(m_ra), PW'(1'b1));

        // Reset while stall and flush are both asserted
        drive(1, 1, 1, 1, ones, 1, 31, 3, 31, 31);
        @(posedge clk); #1;
        n_vec++;
        chk("rst_stall_cnt",     400, PW'(m_cnt), PW'(16'd0));
        chk("rst_sat_stall_cnt", 400, PW'(s_cnt), PW'(4'd0));
        chk("rst_valid",         400, PW'(m_valid), PW'(1'b0));
        chk("rst_payload",       400, m_pay, z);
        chk("rst_tnew",          400, PW'(m_tnew), PW'(2'd0));
        @(negedge clk);

        // Counter restarts from zero after reset
        drive(0, 1, 0, 1, ones, 1, 31, 3, 31, 31);
        @(posedge clk); #1;
        n_vec++;
        chk("post_rst_cnt",   401, PW'(m_cnt), PW'(16'd1));
        chk("post_rst_valid", 401, PW'(m_valid), PW'(1'b0));
        chk("post_rst_hit_a", 401, PW'(m_ha), PW'(1'b0));
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
